// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcode/ALUOp/alu_src_b constants and the control word
// shared by the multi-cycle RV32I control FSM and its output decoder.
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: state -> datapath control word; only FETCH looks at mem_ready
// (IR and PC load together when the fetch completes).
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFF;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multi-cycle RV32I datapath with retire counter.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);
`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    state_t cur, nxt;
    ctrl_t  ctrl;

    ctrl_out_decode u_dec (.state(cur), .mem_ready(mem_ready), .ctrl(ctrl));

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEMADR :
                            (opcode == OP_R)      ? S_EXEC   :
                            (opcode == OP_BRANCH) ? S_BRANCH : ILL_NEXT;
            S_MEMADR: nxt = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_TRAP:   nxt = ILL_NEXT;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur     <= S_FETCH;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur != S_FETCH && nxt == S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

    // write/request strobes are masked combinationally so a reset cycle never commits anything
    assign pc_write      = ctrl.pc_write & rst;
    assign pc_write_cond = ctrl.pc_write_cond & rst;
    assign mem_read      = ctrl.mem_read & rst;
    assign mem_write     = ctrl.mem_write & rst;
    assign ir_write      = ctrl.ir_write & rst;
    assign reg_write     = ctrl.reg_write & rst;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign state         = cur;
`ifdef ILLEGAL_TRAP_EN
    assign illegal = (cur == S_TRAP);
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed vectors with hand-computed expectations for the control FSM
// (CNT_W=4 so the retire counter wrap is reachable).
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic [3:0] retired;
    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_ret;

    multicycle_ctrl_fsm #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .retired(retired),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; opcode = 7'b0; mem_ready = 1'b0;
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_retired", retired, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_ir_write", ir_write, 0);
        rst = 1'b1;
        #1;
        chk("fetch_wait_mem_read", mem_read, 1);
        chk("fetch_wait_ir_write", ir_write, 0);
        step();
        chk("fetch_hold", state, 0);

        // R-type
        opcode = 7'b0110011; mem_ready = 1'b1;
        #1;
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_write", pc_write, 1);
        chk("fetch_src_b", alu_src_b, 2'b01);
        chk("fetch_i_or_d", i_or_d, 0);
        step();
        chk("r_decode", state, 1);
        chk("decode_src_b", alu_src_b, 2'b11);
        chk("decode_reg_write", reg_write, 0);
        step();
        chk("r_exec", state, 6);
        chk("exec_alu_op", alu_op, 2'b10);
        chk("exec_src_a", alu_src_a, 1);
        chk("exec_src_b", alu_src_b, 2'b00);
        chk("exec_reg_write", reg_write, 0);
        step();
        chk("r_aluwb", state, 7);
        chk("aluwb_reg_write", reg_write, 1);
        chk("aluwb_retired", retired, 0);
        step();
        chk("r_back_fetch", state, 0);
        chk("r_retired", retired, 1);

        // load with 3 wait cycles in MEMRD
        opcode = 7'b0000011;
        step();
        chk("ld_decode", state, 1);
        step();
        chk("ld_memadr", state, 2);
        chk("memadr_src_b", alu_src_b, 2'b10);
        chk("memadr_src_a", alu_src_a, 1);
        step();
        mem_ready = 1'b0;
        #1;
        chk("ld_memrd", state, 3);
        chk("memrd_read", mem_read, 1);
        chk("memrd_i_or_d", i_or_d, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_memrd_hold", state, 3);
        end
        mem_ready = 1'b1;
        step();
        chk("ld_memwb", state, 4);
        chk("memwb_mem_to_reg", mem_to_reg, 1);
        chk("memwb_reg_write", reg_write, 1);
        step();
        chk("ld_back_fetch", state, 0);
        chk("ld_retired", retired, 2);

        // branch
        opcode = 7'b1100011;
        step(); step();
        chk("br_state", state, 8);
        chk("br_alu_op", alu_op, 2'b01);
        chk("br_pc_write_cond", pc_write_cond, 1);
        chk("br_pc_source", pc_source, 1);
        step();
        chk("br_back_fetch", state, 0);
        chk("br_retired", retired, 3);

        // store
        opcode = 7'b0100011;
        step(); step(); step();
        chk("st_memwr", state, 5);
        chk("st_mem_write", mem_write, 1);
        step();
        chk("st_back_fetch", state, 0);
        chk("st_retired", retired, 4);

        // store aborted by reset in MEMWR
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        chk("st2_memwr", state, 5);
        chk("st2_mem_write", mem_write, 1);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        chk("rst_mid_mem_write", mem_write, 0);
        step();
        chk("rst_mid_state", state, 0);
        chk("rst_mid_retired", retired, 0);
        rst = 1'b1;

        // illegal opcode
        opcode = 7'b0000000;
        step(); step();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            chk("trap_state", state, 9);
            chk("trap_illegal", illegal, 1);
            chk("trap_retired", retired, 0);
            chk("trap_mem_read", mem_read, 0);
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("trap_reset_state", state, 0);
        exp_ret = 4'd0;
`else
        chk("nop_state", state, 0);
        chk("nop_retired", retired, 1);
        chk("nop_illegal", illegal, 0);
        exp_ret = 4'd1;
`endif

        // 16 R-type instructions wrap the 4-bit counter back to its start
        opcode = 7'b0110011;
        for (int i = 0; i < 16; i++) begin
            step(); step(); step(); step();
            exp_ret = exp_ret + 4'd1;
            chk("wrap_retired", retired, exp_ret);
        end
`ifdef ILLEGAL_TRAP_EN
        chk("wrap_final", retired, 0);
`else
        chk("wrap_final", retired, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
